// File: rtl/regfile_2w2r.sv
// regfile_2w2r: two-write / two-read architectural register file (optional REGFILE_WB_BYPASS_EN forwards same-edge writes).
// Latency: reads registered, data and rvalid one edge after re; writes visible to reads issued at the next edge.
// Backpressure: none; writes are always accepted and reads never stall.
module regfile_2w2r #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        write,
  input  logic [DATA_W-1:0] wr1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wr2,
  input  logic [ADDR_W-1:0] wa2,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              rvalid
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              we1;
  logic              we2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;

  // Writes aimed at the hardwired zero register never reach storage.
  assign we1 = write[0] && !((ZERO_REG != 0) && (wa1 == '0));
  assign we2 = write[1] && !((ZERO_REG != 0) && (wa2 == '0));

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = mem[a];
`ifdef REGFILE_WB_BYPASS_EN
    // Port2 checked last so it wins when both ports hit the same address.
    if (we1 && (wa1 == a)) v = wr1;
    if (we2 && (wa2 == a)) v = wr2;
`endif
    if ((ZERO_REG != 0) && (a == '0)) v = '0;
    return v;
  endfunction

  always_comb begin
    rdata1 = read_port(ra1);
    rdata2 = read_port(ra2);
  end

  // Port2 assignment follows port1 so it takes priority on address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (we1) mem[wa1] <= wr1;
      if (we2) mem[wa2] <= wr2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1    <= '0;
      rd2    <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) begin
        rd1 <= rdata1;
        rd2 <= rdata2;
      end
    end
  end

endmodule

// File: tb/tb_regfile_2w2r.sv
// Scoreboard bench for regfile_2w2r: directed scenarios plus random traffic against an array model.
module tb_regfile_2w2r;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  typedef logic [DATA_W-1:0] mem_t [DEPTH];
  typedef struct {
    logic              vld;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        write;
  logic [DATA_W-1:0] wr1, wr2;
  logic [ADDR_W-1:0] wa1, wa2;
  logic              re;
  logic [ADDR_W-1:0] ra1, ra2;
  logic [DATA_W-1:0] rd1, rd2;
  logic              rvalid;

  mem_t        ref_mem;
  logic [DATA_W-1:0] hold1, hold2;
  exp_t        q[$];
  int          passed = 0;
  int          total  = 0;

  regfile_2w2r #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .write(write),
    .wr1(wr1), .wa1(wa1), .wr2(wr2), .wa2(wa2),
    .re(re), .ra1(ra1), .ra2(ra2),
    .rd1(rd1), .rd2(rd2), .rvalid(rvalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [DATA_W-1:0] model_read(input mem_t m, input logic [ADDR_W-1:0] a);
    return (a == 0) ? '0 : m[a];
  endfunction

  // Drives one clock of stimulus (at negedge+1) and queues what the outputs must show after the coming edge.
  task automatic cycle(input logic [1:0] w,
                       input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                       input logic [ADDR_W-1:0] a2, input logic [DATA_W-1:0] d2,
                       input logic r, input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    mem_t post;
    mem_t src;
    exp_t e;
    write = w; wa1 = a1; wr1 = d1; wa2 = a2; wr2 = d2;
    re = r; ra1 = r1; ra2 = r2;
    post = ref_mem;
    if (w[0] && a1 != 0) post[a1] = d1;
    if (w[1] && a2 != 0) post[a2] = d2;
`ifdef REGFILE_WB_BYPASS_EN
    src = post;
`else
    src = ref_mem;
`endif
    if (r) begin
      hold1 = model_read(src, r1);
      hold2 = model_read(src, r2);
    end
    e.vld = r; e.d1 = hold1; e.d2 = hold2;
    q.push_back(e);
    ref_mem = post;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    cycle(2'b00, '0, '0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    hold1 = '0;
    hold2 = '0;
    q.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && q.size() > 0) begin
      e = q.pop_front();
      check("rvalid", {31'b0, rvalid}, {31'b0, e.vld});
      check("rd1", rd1, e.d1);
      check("rd2", rd2, e.d2);
    end
  end

  initial begin
    logic [ADDR_W-1:0] a1, a2, r1, r2;
    rst = 1'b1; write = '0; wr1 = '0; wr2 = '0; wa1 = '0; wa2 = '0;
    re = 1'b0; ra1 = '0; ra2 = '0;
    model_reset();
    #1;
    check("reset_rvalid", {31'b0, rvalid}, 32'd0);
    check("reset_rd1", rd1, '0);
    check("reset_rd2", rd2, '0);
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;

    // Dual write to distinct addresses, then read both.
    cycle(2'b11, 5'd3, 32'h11111111, 5'd7, 32'h22222222, 1'b0, '0, '0);
    cycle(2'b00, '0, '0, '0, '0, 1'b1, 5'd3, 5'd7);
    // Collision: port2 must win.
    cycle(2'b11, 5'd9, 32'hAAAA0000, 5'd9, 32'h5555FFFF, 1'b0, '0, '0);
    cycle(2'b00, '0, '0, '0, '0, 1'b1, 5'd9, 5'd9);
    // Zero register: dropped write, and a dual write where the other port still commits.
    cycle(2'b01, 5'd0, 32'hDEADBEEF, '0, '0, 1'b0, '0, '0);
    cycle(2'b00, '0, '0, '0, '0, 1'b1, 5'd0, 5'd0);
    cycle(2'b11, 5'd0, 32'hCAFEF00D, 5'd4, 32'h12345678, 1'b0, '0, '0);
    cycle(2'b10, '0, '0, 5'd6, 32'h0BADCAFE, 1'b1, 5'd0, 5'd4);
    // Same-edge read/write of register 5, then a follow-up read.
    cycle(2'b01, 5'd5, 32'h1, '0, '0, 1'b0, '0, '0);
    cycle(2'b01, 5'd5, 32'h2, '0, '0, 1'b1, 5'd5, 5'd5);
    cycle(2'b00, '0, '0, '0, '0, 1'b1, 5'd5, 5'd6);
    // Streaming reads with no bubbles, then drop re and check hold.
    for (int i = 0; i < 10; i++) cycle(2'b00, '0, '0, '0, '0, 1'b1, 5'(i), 5'(9 - i));
    idle();
    idle();

    // Random traffic; narrow address range half the time to force collisions and bypass hits.
    for (int n = 0; n < 400; n++) begin
      a1 = 5'($urandom); a2 = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom);
      if ($urandom_range(1) == 1) begin
        a1 = 5'($urandom_range(3)); a2 = 5'($urandom_range(3));
        r1 = 5'($urandom_range(3)); r2 = 5'($urandom_range(3));
      end
      cycle(2'($urandom), a1, $urandom, a2, $urandom, 1'($urandom), r1, r2);
    end

    // Fill every register, end on a read so rvalid is high before reset.
    for (int i = 0; i < DEPTH; i += 2)
      cycle(2'b11, 5'(i), $urandom | 32'h1, 5'(i + 1), $urandom | 32'h1, 1'b1, 5'(i + 1), 5'(i + 1));
    // Mid-cycle asynchronous reset with a write and read in flight.
    write = 2'b11; wa1 = 5'd10; wr1 = 32'hFFFF0000; wa2 = 5'd11; wr2 = 32'h0000FFFF;
    re = 1'b1; ra1 = 5'd10; ra2 = 5'd11;
    #2 rst = 1'b1;
    #1;
    check("midrst_rvalid", {31'b0, rvalid}, 32'd0);
    check("midrst_rd1", rd1, '0);
    check("midrst_rd2", rd2, '0);
    model_reset();
    @(negedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i += 2) cycle(2'b00, '0, '0, '0, '0, 1'b1, 5'(i), 5'(i + 1));
    idle();

    check("queue_drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
